// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network front end.
// Holds the rate-encoder state enum and the default intensity width.
package snn_pkg;

  // Encoder control states: LOAD collects intensities, RUN presents the
  // window, DONE is the single closing cycle.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  localparam int PIX_W_DEF = 8;

endpackage

// File: rtl/rate_accumulator.sv
// One rate-coded neuron driver: stores an intensity word and, while running,
// adds it into a PIX_W-bit phase accumulator every cycle. The carry-out of
// that addition is the spike, registered for the following cycle.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        capture data_i as this node's intensity
//   data_i        unsigned intensity word
//   clr_i         zero the accumulator (start of a new window)
//   run_i         window cycle: accumulate and emit carry
//   spike_o       registered spike, 0 whenever the previous cycle was idle
module rate_accumulator
  import snn_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic             clr_i,
  input  logic             run_i,
  output logic             spike_o
);

  logic [PIX_W-1:0] intensity_q;
  logic [PIX_W-1:0] acc_q;
  logic [PIX_W:0]   sum_p0;
  logic             spike_p1;

  // Unsigned add widened by one bit so the wrap becomes an explicit carry.
  function automatic logic [PIX_W:0] acc_add(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign sum_p0 = acc_add(acc_q, intensity_q);

  // Stage p0 -> p1: accumulator update and carry capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intensity_q <= '0;
      acc_q       <= '0;
      spike_p1    <= 1'b0;
    end else begin
      if (load_i) intensity_q <= data_i;
      if (clr_i) begin
        acc_q <= '0;
      end else if (run_i) begin
        acc_q <= sum_p0[PIX_W-1:0];
      end
      spike_p1 <= run_i & sum_p0[PIX_W];
    end
  end

  assign spike_o = spike_p1;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder feeding a spiking network: loads one intensity per node over a
// ready/valid stream, then presents a WINDOW-cycle spike train in which each
// node fires floor(WINDOW*intensity/2^PIX_W) times, evenly spaced.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   pix_valid_i   intensity word offered
//   pix_data_i    intensity for the next node index
//   pix_ready_o   encoder accepts a word this cycle (LOAD only)
//   spikes_o      registered spike vector, one bit per node
//   active_o      registered; high on every cycle spikes_o carries window data
//   done_o        one-cycle pulse on the final active cycle
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int NUM_NODES = 1,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int WINDOW    = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pix_valid_i,
  input  logic [PIX_W-1:0]     pix_data_i,
  output logic                 pix_ready_o,
  output logic [NUM_NODES-1:0] spikes_o,
  output logic                 active_o,
  output logic                 done_o
);

  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int CNT_W = $clog2(WINDOW + 1);

  enc_state_t       state_q;
  enc_state_t       state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] win_q;
  logic             accept;
  logic             last_word;
  logic             last_cyc;
  logic             run;
  logic             vld_p1;

  assign accept    = (state_q == ST_LOAD) && pix_valid_i;
  assign last_word = accept && (idx_q == IDX_W'(NUM_NODES - 1));
  assign run       = (state_q == ST_RUN);
  assign last_cyc  = run && (win_q == CNT_W'(WINDOW - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (last_word) state_d = ST_RUN;
      ST_RUN:  if (last_cyc)  state_d = ST_DONE;
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Stage p0 -> p1: control state; active tracks the RUN cycle just completed
  // so it lines up with the registered spikes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      win_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= run;
      if (last_word) begin
        idx_q <= '0;
      end else if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (last_word) begin
        win_q <= '0;
      end else if (run) begin
        win_q <= win_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
    rate_accumulator #(
      .PIX_W(PIX_W)
    ) u_acc (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (accept && (idx_q == IDX_W'(i))),
      .data_i (pix_data_i),
      .clr_i  (last_word),
      .run_i  (run),
      .spike_o(spikes_o[i])
    );
  end

  // Reset masks ready and done combinationally so an aborted window never
  // shows a spurious accept or completion in the reset cycle itself.
  assign pix_ready_o = (state_q == ST_LOAD) && !rst_i;
  assign done_o      = (state_q == ST_DONE) && !rst_i;
  assign active_o    = vld_p1;

endmodule

// File: tb/tb_spike_rate_encoder.sv
module tb_spike_rate_encoder;

  localparam int N   = 4;
  localparam int PW  = 8;
  localparam int WIN = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          pix_valid_i;
  logic [PW-1:0] pix_data_i;
  logic          pix_ready_o;
  logic [N-1:0]  spikes_o;
  logic          active_o;
  logic          done_o;

  int n_tests = 0;
  int n_fail  = 0;

  int intens[N];
  int cnt[N];
  int first[N];
  int acyc, ready_low, dones, done_at, bad_pat, bad_zero, bad_rdy;
  bit finished;

  always #5 clk_i = ~clk_i;

  spike_rate_encoder #(
    .NUM_NODES(N),
    .PIX_W    (PW),
    .WINDOW   (WIN)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .pix_valid_i(pix_valid_i),
    .pix_data_i (pix_data_i),
    .pix_ready_o(pix_ready_o),
    .spikes_o   (spikes_o),
    .active_o   (active_o),
    .done_o     (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Offer four words; 'gap' idle cycles (valid low, junk data) follow each
  // word except the last.
  task automatic load4(input int w0, input int w1, input int w2, input int w3, input int gap);
    int w[N];
    w = '{w0, w1, w2, w3};
    bad_rdy = 0;
    for (int i = 0; i < N; i++) begin
      intens[i] = w[i];
      @(negedge clk_i);
      if (pix_ready_o !== 1'b1) bad_rdy++;
      pix_valid_i = 1'b1;
      pix_data_i  = PW'(w[i]);
      if (i < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk_i);
          if (pix_ready_o !== 1'b1) bad_rdy++;
          pix_valid_i = 1'b0;
          pix_data_i  = 8'hEE;
        end
      end
    end
  endtask

  // Observe one window until the encoder is ready again. Valid is held high
  // with junk data while not ready. If abort_at > 0, reset is raised on that
  // active cycle and the task returns.
  task automatic watch(input int abort_at, output bit aborted);
    acyc = 0; ready_low = 0; dones = 0; done_at = -1;
    bad_pat = 0; bad_zero = 0; finished = 1'b0; aborted = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      first[i] = -1;
    end
    for (int c = 0; c < WIN + 50 && !finished && !aborted; c++) begin
      @(negedge clk_i);
      if (pix_ready_o === 1'b1) begin
        finished = 1'b1;
        pix_valid_i = 1'b0;
      end else begin
        ready_low++;
        pix_valid_i = 1'b1;
        pix_data_i  = 8'hAA;
      end
      if (active_o === 1'b1) begin
        acyc++;
        for (int i = 0; i < N; i++) begin
          bit e;
          e = (((acyc * intens[i]) >> PW) != (((acyc - 1) * intens[i]) >> PW));
          if (spikes_o[i] !== e) bad_pat++;
          if (spikes_o[i] === 1'b1) begin
            cnt[i]++;
            if (first[i] < 0) first[i] = acyc;
          end
        end
      end else if (spikes_o !== '0) begin
        bad_zero++;
      end
      if (done_o === 1'b1) begin
        dones++;
        done_at = (active_o === 1'b1) ? acyc : -1;
      end
      if (abort_at > 0 && acyc == abort_at) begin
        aborted = 1'b1;
        rst_i = 1'b1;
        pix_valid_i = 1'b0;
      end
    end
  endtask

  task automatic verify(input string nm, input int c0, input int c1, input int c2, input int c3,
                        input int f0, input int f1, input int f2, input int f3);
    int ec[N];
    int ef[N];
    ec = '{c0, c1, c2, c3};
    ef = '{f0, f1, f2, f3};
    check($sformatf("%s finished", nm), finished, 1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s count[%0d]", nm, i), cnt[i], ec[i]);
      check($sformatf("%s first[%0d]", nm, i), first[i], ef[i]);
    end
    check($sformatf("%s active cycles", nm), acyc, WIN);
    check($sformatf("%s done pulses", nm), dones, 1);
    check($sformatf("%s done position", nm), done_at, WIN);
    check($sformatf("%s ready low cycles", nm), ready_low, WIN + 1);
    check($sformatf("%s spike pattern errs", nm), bad_pat, 0);
    check($sformatf("%s idle spike errs", nm), bad_zero, 0);
    check($sformatf("%s load ready errs", nm), bad_rdy, 0);
  endtask

  initial begin
    bit ab;
    rst_i = 1'b1;
    pix_valid_i = 1'b0;
    pix_data_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset ready", pix_ready_o, 0);
    check("reset spikes", spikes_o, 0);
    check("reset active", active_o, 0);
    check("reset done", done_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post-reset ready", pix_ready_o, 1);
    check("post-reset active", active_o, 0);

    load4(0, 64, 128, 255, 0);
    watch(-1, ab);
    verify("win1", 0, 64, 128, 255, -1, 4, 2, 2);

    load4(0, 64, 128, 255, 0);
    watch(-1, ab);
    verify("b2b", 0, 64, 128, 255, -1, 4, 2, 2);

    load4(200, 1, 17, 100, 1);
    watch(-1, ab);
    verify("toggled", 200, 1, 17, 100, 2, 256, 16, 3);

    load4(0, 64, 128, 255, 7);
    watch(-1, ab);
    verify("partial", 0, 64, 128, 255, -1, 4, 2, 2);

    load4(0, 64, 128, 255, 0);
    watch(100, ab);
    check("abort reached", ab, 1);
    @(negedge clk_i);
    check("abort active", active_o, 0);
    check("abort spikes", spikes_o, 0);
    check("abort done", done_o, 0);
    check("abort ready in reset", pix_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort ready after", pix_ready_o, 1);
    check("abort done after", done_o, 0);

    load4(0, 64, 128, 255, 0);
    watch(-1, ab);
    verify("reload", 0, 64, 128, 255, -1, 4, 2, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
